spi_cmd_master: RTL and testbench
=================================

# spi_cmd_master

Single-clock SPI master that serialises traffic-light register-write commands into the framed bit stream expected by the downstream SPI slave (preamble `0`, start `1`, then 6 payload bits). It sits between the controller/CPU side of the traffic-light design, which issues `{wen, addr[1:0], data[2:0]}` commands through a valid/ready handshake, and the SPI pins `spi_sclk`/`spi_mosi`/`spi_ss_n`. It derives `spi_sclk` by dividing the system clock and owns all frame timing.

## Interface
- `CLK_DIV`, default 4: clk cycles per sclk half-period; legal range 1..255.
- `GAP_SLOTS`, default 2: number of sclk periods with `spi_ss_n` high after each frame; legal range 1..7.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_wen`  in  1: write-enable bit of the command.
- `cmd_addr`  in  2: register address.
- `cmd_data`  in  3: register data.
- `busy`  out  1: a frame or gap is in progress.
- `done`  out  1: one-clk pulse at the end of the gap.
- `spi_sclk`  out  1: serial clock; idles low.
- `spi_mosi`  out  1: serial data, MSB first.
- `spi_ss_n`  out  1: active-low select.
- `spi_miso`  in  1: unused; no effect on any output.

## Operation
- Slot = one sclk period = 2*CLK_DIV clk cycles. First half: sclk low. Second half: sclk high. `spi_mosi` and `spi_ss_n` change only at slot start, while sclk is low; the slave samples on the sclk rising edge.
- The frame has 9 + GAP_SLOTS slots:
  - slot 0: preamble `0`.
  - slot 1: start `1`.
  - slots 2..7: payload `wen, addr[1], addr[0], data[2], data[1], data[0]`.
  - slot 8: trailer `0`. It gives the slave one more edge to latch data.
  - slots 9..8+GAP_SLOTS: `spi_ss_n`=1 and `spi_mosi`=0, with sclk still toggling, so the slave clears its shift register.
- `spi_ss_n`=0 for slots 0..8 only.
- States:
  - IDLE: `cmd_ready`=1, `busy`=0, sclk=0, `spi_ss_n`=1, `spi_mosi`=0. On `cmd_valid && cmd_ready` the command is captured into a 6-bit shift register and the state goes to FRAME.
  - FRAME: slots 0..8. Moves to GAP after the last clk of slot 8.
  - GAP: moves to IDLE after its last clk; `done`=1 for that one clk.
- `cmd_ready`=0 in FRAME and GAP. The captured command is immune to input changes after acceptance.
- `busy` = (state != IDLE).
- Counters:
  - `div_cnt`: 0..CLK_DIV-1, width 8.
  - `phase`: 1 bit, selects the sclk half.
  - `slot_cnt`: 4 bits, 0..8+GAP_SLOTS, with no wrap beyond. It returns to 0 on the IDLE entry.
- All SPI outputs are registered, so there are no glitches.
- Reset (asserted at any time, including mid-frame) forces every output to its reset value immediately:
  - `cmd_ready`=0 while `rst`=1, then 1 on the first clk after release.
  - `busy`=0, `done`=0, `spi_sclk`=0, `spi_ss_n`=1, `spi_mosi`=0.
  - The partial frame is abandoned, not resumed.

## Timing
- Acceptance at clk edge T: `spi_ss_n` falls and `spi_mosi`=0 (preamble) at T+1, and the first sclk rise is at T+1+CLK_DIV.
- Frame length: (9+GAP_SLOTS)*2*CLK_DIV clk cycles from T+1. With the defaults this is 88.
- `done` is high during the final clk of GAP. `cmd_ready` returns high on the next clk, and the next acceptance is possible on that clk.
- A command held valid back-to-back gives a minimum of 1 idle clk between frames.
- `cmd_valid` asserted during FRAME or GAP is ignored until IDLE. There is no queueing.

## Structure
- Shared package `traffic_spi_pkg`:
  - frame constants `PREAMBLE_SLOT`=0, `START_SLOT`=1, `PAYLOAD_FIRST`=2, `PAYLOAD_LAST`=7, `TRAILER_SLOT`=8, `PAYLOAD_W`=6.
  - state enum IDLE/FRAME/GAP.
  - address width 2 and data width 3, also used by the slave side.
- One sub-module, `spi_sclk_gen`. It holds the `div_cnt` and `phase` logic, and outputs sclk, a `slot_start` pulse and a `slot_end` pulse. It is enabled by `busy`.

## Test plan
- CLK_DIV=2, command wen=1, addr=2, data=5: sampled mosi on rising edges is 0,1,1,1,0,1,0,1,0 with ss_n low; `spi_ss_n` is high for 2 further sclk rises; `done` comes 44 clks after T+1.
- `cmd_valid` held high with 3 different commands: three frames are sent; `cmd_ready` is high for exactly 1 clk between frames; `cmd_*` changes mid-frame do not alter the bits.
- `rst` asserted at slot 4 (CLK_DIV=4): in the same cycle `spi_ss_n`=1, `spi_sclk`=0, `spi_mosi`=0 and `busy`=0; after release a new command produces a complete, correct frame.
- CLK_DIV=1: sclk toggles every clk, the frame is 22 clks, and `spi_mosi` transitions only while sclk is low.
- Loopback into the slave model with all 64 `{wen,addr,data}` values: the slave reports matching addr, data and wen; `spi_miso` is tied to random values and has no effect.

Source files
------------

// File: rtl/traffic_spi_pkg.sv
// Shared constants and types for the traffic-light SPI command link.
package traffic_spi_pkg;

  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 3;
  localparam int PAYLOAD_W = 6;

  localparam logic [3:0] PREAMBLE_SLOT = 4'd0;
  localparam logic [3:0] START_SLOT    = 4'd1;
  localparam logic [3:0] PAYLOAD_FIRST = 4'd2;
  localparam logic [3:0] PAYLOAD_LAST  = 4'd7;
  localparam logic [3:0] TRAILER_SLOT  = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Serial clock divider: one slot is two halves of CLK_DIV clk cycles each,
// low half first. Idles with sclk low and counters cleared while disabled.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic slot_start,
  output logic slot_end
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       phase;

  // Divider counter and half-period phase; phase drives sclk directly so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  assign sclk       = phase;
  assign slot_start = en && !phase && (div_cnt == 8'd0);
  assign slot_end   = en &&  phase && (div_cnt == DIV_LAST);

endmodule

// File: rtl/spi_cmd_master.sv
// SPI master that frames {wen, addr, data} commands as
// preamble 0, start 1, 6 payload bits, trailer 0, then a deselected gap.
//
// state | meaning
// IDLE  | ready for a command, SPI pins parked
// FRAME | slots 0..8 with ss_n low
// GAP   | ss_n high, sclk still running, done on the last clk
module spi_cmd_master
  import traffic_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned GAP_SLOTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wen,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_ss_n,
  input  logic              spi_miso
);

  localparam logic [3:0] LAST_SLOT = 4'(TRAILER_SLOT + GAP_SLOTS);

  state_t                 state_q, state_d;
  logic                   ready_q;
  logic [PAYLOAD_W-1:0]   shreg;
  logic [3:0]             slot_cnt;
  logic [3:0]             slot_nxt;
  logic                   mosi_q, ss_n_q;
  logic                   accept;
  logic                   slot_start, slot_end;
  logic                   gap_last;
  logic                   unused_miso;

  // The slave never drives anything back that this block cares about.
  assign unused_miso = spi_miso;

  assign busy      = (state_q != IDLE);
  assign cmd_ready = ready_q && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign gap_last  = (state_q == GAP) && slot_end && (slot_cnt == LAST_SLOT);
  assign done      = gap_last;
  assign slot_nxt  = slot_cnt + 4'd1;
  assign spi_mosi  = mosi_q;
  assign spi_ss_n  = ss_n_q;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (busy),
    .sclk       (spi_sclk),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FRAME;
      FRAME:   if (slot_end && (slot_cnt == TRAILER_SLOT)) state_d = GAP;
      GAP:     if (gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, slot counting and registered SPI pins. Pins are loaded
  // on the last clk of a slot so they change exactly at the next slot start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      shreg    <= '0;
      slot_cnt <= '0;
      mosi_q   <= 1'b0;
      ss_n_q   <= 1'b1;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        shreg    <= {cmd_wen, cmd_addr, cmd_data};
        slot_cnt <= PREAMBLE_SLOT;
        ss_n_q   <= 1'b0;
        mosi_q   <= 1'b0;
      end else if (busy) begin
        if (slot_start && (slot_cnt >= PAYLOAD_FIRST) && (slot_cnt <= PAYLOAD_LAST))
          shreg <= {shreg[PAYLOAD_W-2:0], 1'b0};
        if (gap_last) begin
          slot_cnt <= '0;
          ss_n_q   <= 1'b1;
          mosi_q   <= 1'b0;
        end else if (slot_end) begin
          slot_cnt <= slot_nxt;
          ss_n_q   <= (slot_nxt > TRAILER_SLOT);
          if (slot_nxt == START_SLOT)
            mosi_q <= 1'b1;
          else if ((slot_nxt >= PAYLOAD_FIRST) && (slot_nxt <= PAYLOAD_LAST))
            mosi_q <= shreg[PAYLOAD_W-1];
          else
            mosi_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: driver pushes expected frames, a
// slave-side monitor decodes the pins and compares.
module tb_spi_cmd_master;

  localparam int CLK_DIV    = 2;
  localparam int GAP_SLOTS  = 2;
  localparam int FRAME_CLKS = (9 + GAP_SLOTS) * 2 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_wen = 1'b0;
  logic [1:0] cmd_addr = 2'd0;
  logic [2:0] cmd_data = 3'd0;
  logic       busy, done, spi_sclk, spi_mosi, spi_ss_n;
  logic       spi_miso = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [5:0] exp_q[$];
  int         t_q[$];

  // slave model state
  logic [8:0] sh = '0;
  int         nb = 0;
  int         gap = 0;
  logic       sclk_p = 1'b0, ssn_p = 1'b1, mosi_p = 1'b0;

  spi_cmd_master #(.CLK_DIV(CLK_DIV), .GAP_SLOTS(GAP_SLOTS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wen   (cmd_wen),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .done      (done),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_ss_n  (spi_ss_n),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_cmd(input logic [5:0] c);
    {cmd_wen, cmd_addr, cmd_data} = c;
  endtask

  // Present one command, wait for acceptance, then scramble the inputs mid-frame.
  task automatic send(input logic [5:0] c);
    int w;
    @(negedge clk);
    set_cmd(c);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      exp_q.push_back(c);
      t_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      set_cmd(~c);
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!done && w < 500);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // Slave-side monitor and scoreboard checker.
  always @(negedge clk) begin
    logic [5:0] e;
    int t;
    if (rst) begin
      nb = 0;
      gap = 0;
    end else begin
      if (spi_mosi != mosi_p) chk("mosi_change_sclk_low", int'(spi_sclk), 0);
      if (!spi_ss_n && ssn_p) begin
        nb = 0;
        sh = '0;
        gap = 0;
      end
      if (spi_sclk && !sclk_p) begin
        if (!spi_ss_n) begin
          sh = {sh[7:0], spi_mosi};
          nb++;
        end else begin
          gap++;
        end
      end
      if (spi_ss_n && !ssn_p) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_bits", int'(sh), int'({1'b0, 1'b1, e, 1'b0}));
          chk("frame_len", nb, 9);
        end
      end
      if (done) begin
        chk("gap_rises", gap, GAP_SLOTS);
        if (t_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          t = t_q.pop_front();
          chk("done_latency", cyc - t + 1, FRAME_CLKS);
        end
      end
    end
    sclk_p = spi_sclk;
    ssn_p  = spi_ss_n;
    mosi_p = spi_mosi;
  end

  // miso toggles randomly throughout; it must have no effect.
  initial begin
    forever begin
      @(negedge clk);
      spi_miso = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [5:0] b2b[3];
    int w;
    b2b[0] = 6'b011001;
    b2b[1] = 6'b100110;
    b2b[2] = 6'b111111;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ss_n", int'(spi_ss_n), 1);
    chk("rst_sclk", int'(spi_sclk), 0);
    chk("rst_mosi", int'(spi_mosi), 0);
    chk("rst_done", int'(done), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    // reference frame: wen=1 addr=2 data=5 -> 0,1,1,1,0,1,0,1,0
    send(6'b110101);
    wait_done();

    // back-to-back with valid held; inputs move to the next command mid-frame
    @(negedge clk);
    set_cmd(b2b[0]);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        wait_done();
        @(negedge clk);
        chk("b2b_ready_high", int'(cmd_ready), 1);
      end
      exp_q.push_back(b2b[k]);
      t_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      if (k < 2) set_cmd(~b2b[k+1]);
      else       cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_ready_low", int'(cmd_ready), 0);
      repeat (10) @(negedge clk);
      if (k < 2) set_cmd(b2b[k+1]);
    end
    wait_done();

    // reset mid-frame while slot 4 (mosi=1) is in its sclk-high half
    send(6'b101010);
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (nb != 5 && w < 500);
    chk("slot4_reached", nb, 5);
    chk("slot4_mosi", int'(spi_mosi), 1);
    rst = 1'b1;
    #1;
    chk("midrst_ss_n", int'(spi_ss_n), 1);
    chk("midrst_sclk", int'(spi_sclk), 0);
    chk("midrst_mosi", int'(spi_mosi), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    if (t_q.size() > 0) void'(t_q.pop_back());
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    send(6'b010011);
    wait_done();

    // loopback over every command value
    for (int i = 0; i < 64; i++) begin
      send(6'(i));
    end
    wait_done();

    w = 0;
    while ((exp_q.size() != 0 || t_q.size() != 0) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("pending_frames", exp_q.size(), 0);
    chk("pending_dones", t_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
